pwm_duty_ramp: RTL and testbench

Soft-start duty-cycle sequencer sitting directly upstream of the PWM generator. Accepts a target duty value and slews its `duty` output toward it in fixed increments at a programmable rate, so that LED and motor loads never see step changes. The `duty` output connects straight to the PWM block's `duty` input and uses the same R+1-bit encoding, where 2^R means 100 %.

---
 rtl/pwm_duty_ramp.sv | 123 ++++++++++++
 tb/tb_pwm_duty_ramp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start duty sequencer in front of the PWM generator.
// Slews `duty` toward a clamped target in step-sized increments, one step
// every rate+1 clocks. Duty encoding is R+1 bits, 2^R = 100 %.
// Optional feature macro: PWM_DUTY_RAMP_FREEZE_EN adds a `freeze` input that
// stalls stepping while a ramp is in progress.
//
// state | meaning
// IDLE  | duty stable at target, prescaler parked at 0
// UP    | duty stepping upward toward tgt_reg
// DOWN  | duty stepping downward toward tgt_reg
module pwm_duty_ramp #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [R:0]            target,
  input  logic                  target_valid,
  input  logic [R-1:0]          step,
  input  logic [TIMER_BITS-1:0] rate,
`ifdef PWM_DUTY_RAMP_FREEZE_EN
  input  logic                  freeze,
`endif
  output logic [R:0]            duty,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [R:0]   FULL = {1'b1, {R{1'b0}}};
  localparam logic [R+1:0] ONE  = (R+2)'(1);

  state_t                state;
  logic [R:0]            duty_reg;
  logic [R:0]            tgt_reg;
  logic [TIMER_BITS-1:0] cnt;
  logic                  busy_reg;
  logic                  done_reg;

  logic [R:0]   tgt_clamped;
  logic [R+1:0] step_eff;
  logic [R+1:0] duty_ext;
  logic [R+1:0] tgt_ext;
  logic [R+1:0] up_sum;
  logic [R+1:0] dn_diff;
  logic         up_hit;
  logic         dn_hit;
  logic         step_now;
  logic         stall;

`ifdef PWM_DUTY_RAMP_FREEZE_EN
  assign stall = freeze;
`else
  assign stall = 1'b0;
`endif

  // Step arithmetic is carried at R+2 bits so overshoot above 2^R and
  // underflow below 0 are both visible before saturation to the target.
  assign tgt_clamped = (target > FULL) ? FULL : target;
  assign step_eff    = (step == '0) ? ONE : {2'b00, step};
  assign duty_ext    = {1'b0, duty_reg};
  assign tgt_ext     = {1'b0, tgt_reg};
  assign up_sum      = duty_ext + step_eff;
  assign dn_diff     = duty_ext - step_eff;
  assign up_hit      = (up_sum >= tgt_ext);
  assign dn_hit      = (step_eff > duty_ext) || (dn_diff <= tgt_ext);
  assign step_now    = (cnt == rate);

  // Ramp FSM: target load has priority over a step landing the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      duty_reg <= '0;
      tgt_reg  <= '0;
      cnt      <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (target_valid) begin
        tgt_reg <= tgt_clamped;
        cnt     <= '0;
        if (tgt_clamped > duty_reg) begin
          state    <= UP;
          busy_reg <= 1'b1;
        end else if (tgt_clamped < duty_reg) begin
          state    <= DOWN;
          busy_reg <= 1'b1;
        end else begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end else if ((state != IDLE) && !stall) begin
        if (step_now) begin
          cnt <= '0;
          if ((state == UP) ? up_hit : dn_hit) begin
            duty_reg <= tgt_reg;
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end else if (state == UP) begin
            duty_reg <= up_sum[R:0];
          end else begin
            duty_reg <= dn_diff[R:0];
          end
        end else begin
          cnt <= cnt + TIMER_BITS'(1);
        end
      end
    end
  end

  assign duty = duty_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: table of ramp vectors plus hand-built retarget,
// freeze and reset sequences. Expected per-cycle outputs are queued as
// stimulus is applied and popped one per clock after each rising edge.
module tb_pwm_duty_ramp;

  localparam int R    = 8;
  localparam int TB   = 15;
  localparam int FULL = 1 << R;

  logic          clk;
  logic          reset_n;
  logic [R:0]    target;
  logic          target_valid;
  logic [R-1:0]  step;
  logic [TB-1:0] rate;
`ifdef PWM_DUTY_RAMP_FREEZE_EN
  logic          freeze;
`endif
  logic [R:0]    duty;
  logic          busy;
  logic          done;

  pwm_duty_ramp #(.R(R), .TIMER_BITS(TB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .target       (target),
    .target_valid (target_valid),
    .step         (step),
    .rate         (rate),
`ifdef PWM_DUTY_RAMP_FREEZE_EN
    .freeze       (freeze),
`endif
    .duty         (duty),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit busy;
    bit done;
  } exp_t;

  typedef struct {
    int tgt;
    int stp;
    int rt;
    int fin;
    int nsteps;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;
  int   exp_duty = 0;
  int   last_duty = 0;
  int   changes = 0;

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input bit b, input bit dn);
    exp_t e;
    e.duty = d;
    e.busy = b;
    e.done = dn;
    sbq.push_back(e);
  endtask

  // Queue the per-clock outputs expected from a ramp starting at d0.
  task automatic gen(input int d0, input int t_raw, input int s_raw,
                     input int rt, input int max_steps, input bit with_load);
    int t;
    int s;
    int d;
    int n;
    t = (t_raw > FULL) ? FULL : t_raw;
    s = (s_raw == 0) ? 1 : s_raw;
    d = d0;
    n = 0;
    if (with_load) begin
      push(d0, t != d0, t == d0);
    end
    while (d != t && n < max_steps) begin
      repeat (rt) push(d, 1'b1, 1'b0);
      if (t > d) d = (d + s >= t) ? t : d + s;
      else       d = (d - s <= t) ? t : d - s;
      push(d, d != t, d == t);
      n++;
    end
    if (d == t) push(d, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sbq.size() > 0) begin
      @(posedge clk);
      #1;
      target_valid = 1'b0;
      e = sbq.pop_front();
      if (int'(duty) != last_duty) changes++;
      last_duty = int'(duty);
      checks++;
      if (int'(duty) != e.duty || busy != e.busy || done != e.done) begin
        errors++;
        $display("FAIL %s @%0t: duty=%0d busy=%0d done=%0d, expected duty=%0d busy=%0d done=%0d",
                 name, $time, duty, busy, done, e.duty, e.busy, e.done);
      end
    end
  endtask

  task automatic load(input int t, input int s, input int rt);
    target       = (R+1)'(t);
    step         = R'(s);
    rate         = TB'(rt);
    target_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{200, 10,  3, 200, 20};
    vecs[1] = '{0,   255, 1, 0,   1};
    vecs[2] = '{400, 100, 2, 256, 3};
    vecs[3] = '{5,   100, 0, 5,   3};
    vecs[4] = '{5,   7,   2, 5,   0};
    vecs[5] = '{0,   0,   0, 0,   5};
    vecs[6] = '{3,   0,   0, 3,   3};
    vecs[7] = '{3,   9,   1, 3,   0};
    vecs[8] = '{511, 255, 0, 256, 1};
    vecs[9] = '{0,   128, 4, 0,   2};

    reset_n      = 1'b0;
    target       = '0;
    target_valid = 1'b0;
    step         = '0;
    rate         = '0;
`ifdef PWM_DUTY_RAMP_FREEZE_EN
    freeze       = 1'b0;
`endif

    #3;
    check_val("reset_duty", int'(duty), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_duty", int'(duty), 0);
    check_val("idle_busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      load(vecs[i].tgt, vecs[i].stp, vecs[i].rt);
      changes   = 0;
      last_duty = exp_duty;
      gen(exp_duty, vecs[i].tgt, vecs[i].stp, vecs[i].rt, 1000, 1'b1);
      drain($sformatf("vec%0d", i));
      check_val($sformatf("vec%0d_final", i), int'(duty), vecs[i].fin);
      check_val($sformatf("vec%0d_nsteps", i), changes, vecs[i].nsteps);
      exp_duty = vecs[i].fin;
    end

    // Retarget at duty 80 on the very cycle the next upward step would land.
    load(200, 10, 2);
    last_duty = exp_duty;
    gen(exp_duty, 200, 10, 2, 8, 1'b1);
    repeat (2) push(80, 1'b1, 1'b0);
    drain("retarget_up");
    load(50, 10, 2);
    gen(80, 50, 10, 2, 1000, 1'b1);
    drain("retarget_down");
    check_val("retarget_final", int'(duty), 50);
    exp_duty = 50;

`ifdef PWM_DUTY_RAMP_FREEZE_EN
    load(0, 255, 0);
    gen(exp_duty, 0, 255, 0, 1000, 1'b1);
    drain("freeze_pre");
    load(100, 10, 2);
    gen(0, 100, 10, 2, 4, 1'b1);
    drain("freeze_ramp");
    freeze = 1'b1;
    repeat (20) push(40, 1'b1, 1'b0);
    drain("freeze_hold");
    freeze = 1'b0;
    gen(40, 100, 10, 2, 1000, 1'b0);
    drain("freeze_resume");
    check_val("freeze_final", int'(duty), 100);
    exp_duty = 100;
`endif

    // Reset asserted between clock edges while ramping at duty 120.
    load(0, 255, 0);
    gen(exp_duty, 0, 255, 0, 1000, 1'b1);
    drain("rst_pre");
    load(200, 10, 0);
    gen(0, 200, 10, 0, 12, 1'b1);
    drain("rst_ramp");
    check_val("rst_at_120", int'(duty), 120);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_async_duty", int'(duty), 0);
    check_val("rst_async_busy", int'(busy), 0);
    check_val("rst_async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_abandon_duty", int'(duty), 0);
    check_val("rst_abandon_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
